// File: rtl/hs_fifo.sv
// Show-ahead valid/ready FIFO with flip-flop storage, occupancy count
// and almost-full flag; DEPTH need not be a power of two.
module hs_fifo #(
  parameter int WIDTH       = 1,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "hs_fifo: WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "hs_fifo: DEPTH must be >= 2");
  end
  if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
    $fatal(1, "hs_fifo: AFULL_LEVEL must be in 1..DEPTH");
  end

  typedef logic [WIDTH-1:0] word_t;

  word_t         mem_q [DEPTH];
  word_t         mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic push;
  logic pop;

  // Explicit wrap so non-power-of-two depths never address past the end.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign in_ready    = (count_q != FULL_CNT);
  assign out_valid   = (count_q != '0);
  assign push        = in_valid & in_ready;
  assign pop         = out_valid & out_ready;
  assign out_data    = mem_q[rptr_q];
  assign count       = count_q;
  assign almost_full = (count_q >= AFULL_CNT);

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = in_data;
        wptr_d        = ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_d = ptr_inc(rptr_q);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_hs_fifo.sv
// Bench for hs_fifo: directed vector table on a DEPTH=4 instance and a
// scoreboarded random stream on a DEPTH=3 instance.
module tb_hs_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic       rst4, flush4, iv4, ir4, ov4, ordy4, af4;
  logic [7:0] din4, dout4;
  logic [2:0] cnt4;

  hs_fifo #(.WIDTH(8), .DEPTH(4)) u_d4 (
    .clk         (clk),
    .rst         (rst4),
    .flush       (flush4),
    .in_valid    (iv4),
    .in_ready    (ir4),
    .in_data     (din4),
    .out_valid   (ov4),
    .out_ready   (ordy4),
    .out_data    (dout4),
    .count       (cnt4),
    .almost_full (af4)
  );

  // DEPTH=3 instance
  logic       rst3, flush3, iv3, ir3, ov3, ordy3, af3;
  logic [7:0] din3, dout3;
  logic [1:0] cnt3;

  hs_fifo #(.WIDTH(8), .DEPTH(3)) u_d3 (
    .clk         (clk),
    .rst         (rst3),
    .flush       (flush3),
    .in_valid    (iv3),
    .in_ready    (ir3),
    .in_data     (din3),
    .out_valid   (ov3),
    .out_ready   (ordy3),
    .out_data    (dout3),
    .count       (cnt3),
    .almost_full (af3)
  );

  typedef struct {
    logic       rst;
    logic       flush;
    logic       iv;
    logic [7:0] din;
    logic       ordy;
    logic [2:0] e_cnt;
    logic       e_ir;
    logic       e_ov;
    logic       e_af;
    logic [7:0] e_dat;
    logic       c_dat;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic iv,
                     input logic [7:0] d, input logic o,
                     input logic [2:0] c, input logic ir, input logic ov,
                     input logic af, input logic [7:0] ed, input logic cd);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.din = d; v.ordy = o;
    v.e_cnt = c; v.e_ir = ir; v.e_ov = ov; v.e_af = af;
    v.e_dat = ed; v.c_dat = cd;
    vecs.push_back(v);
  endtask

  // Random-stream scoreboard state
  logic [7:0] sb[$];
  int         pushed;
  bit         did_rst;
  int         cyc;
  bit         do_rst;
  bit         full_m;

  initial begin
    rst4 = 1; flush4 = 0; iv4 = 0; din4 = 0; ordy4 = 0;
    rst3 = 1; flush3 = 0; iv3 = 0; din3 = 0; ordy3 = 0;

    // Expectations describe outputs seen during the cycle, before its edge.
    //  r  f  iv din    or cnt ir ov af dat  chk
    add(0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 1); // reset state
    add(0, 0, 1, 8'h11, 0, 0, 1, 0, 0, 8'h00, 1);
    add(0, 0, 1, 8'h22, 0, 1, 1, 1, 0, 8'h11, 1);
    add(0, 0, 1, 8'h33, 0, 2, 1, 1, 0, 8'h11, 1);
    add(0, 0, 1, 8'h44, 0, 3, 1, 1, 1, 8'h11, 1);
    add(0, 0, 1, 8'h55, 0, 4, 0, 1, 1, 8'h11, 1); // full, refused
    add(0, 0, 1, 8'h66, 1, 4, 0, 1, 1, 8'h11, 1); // full, pop only
    add(0, 0, 0, 8'h00, 0, 3, 1, 1, 1, 8'h22, 1);
    add(0, 0, 0, 8'h00, 1, 3, 1, 1, 1, 8'h22, 1); // down to 2
    for (int i = 0; i < 10; i++) begin
      logic [7:0] ed;
      ed = (i == 0) ? 8'h33 : (i == 1) ? 8'h44 : 8'(8'h80 + i - 2);
      add(0, 0, 1, 8'(8'h80 + i), 1, 2, 1, 1, 0, ed, 1);
    end
    add(0, 0, 1, 8'h90, 0, 2, 1, 1, 0, 8'h88, 1);
    add(0, 1, 1, 8'h91, 1, 3, 1, 1, 1, 8'h88, 1); // flush
    add(0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0);
    add(0, 0, 1, 8'hA5, 0, 0, 1, 0, 0, 8'h00, 0); // latency-1 push
    add(0, 0, 1, 8'h01, 0, 1, 1, 1, 0, 8'hA5, 1);
    add(1, 1, 1, 8'h77, 1, 2, 1, 1, 0, 8'hA5, 1); // mid-op reset
    add(0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 1);
    add(0, 0, 0, 8'h00, 1, 0, 1, 0, 0, 8'h00, 1);

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst4 = vecs[i].rst; flush4 = vecs[i].flush;
      iv4 = vecs[i].iv; din4 = vecs[i].din; ordy4 = vecs[i].ordy;
      chk($sformatf("v%0d count", i), 32'(cnt4), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d in_ready", i), 32'(ir4), 32'(vecs[i].e_ir));
      chk($sformatf("v%0d out_valid", i), 32'(ov4), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d almost_full", i), 32'(af4), 32'(vecs[i].e_af));
      if (vecs[i].c_dat)
        chk($sformatf("v%0d out_data", i), 32'(dout4), 32'(vecs[i].e_dat));
    end
    @(negedge clk);
    rst4 = 0; flush4 = 0; iv4 = 0; ordy4 = 0;

    // DEPTH=3 random stream against a queue model
    @(negedge clk);
    rst3 = 0;
    pushed  = 0;
    did_rst = 0;
    cyc     = 0;
    while ((pushed < 20 || sb.size() != 0) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      do_rst = (pushed == 10) && !did_rst && (sb.size() != 0);
      rst3  = do_rst;
      iv3   = (pushed < 20) && ($urandom_range(0, 3) != 0);
      din3  = 8'($urandom);
      ordy3 = ($urandom_range(0, 3) != 0);
      full_m = (sb.size() == 3);
      chk("d3 count", 32'(cnt3), 32'(sb.size()));
      chk("d3 in_ready", 32'(ir3), 32'(!full_m));
      chk("d3 out_valid", 32'(ov3), 32'(sb.size() != 0));
      chk("d3 almost_full", 32'(af3), 32'(sb.size() >= 2));
      if (do_rst) begin
        did_rst = 1;
        sb.delete();
      end else begin
        if (ordy3 && sb.size() != 0)
          chk("d3 out_data", 32'(dout3), 32'(sb.pop_front()));
        if (iv3 && !full_m) begin
          sb.push_back(din3);
          pushed++;
        end
      end
    end
    n_cmp++;
    if (cyc >= 2000 || !did_rst) begin
      n_err++;
      $display("FAIL d3 stream: cycles %0d reset_seen %0d", cyc, did_rst);
    end
    @(negedge clk);
    iv3 = 0; ordy3 = 0; rst3 = 0;
    chk("d3 drained count", 32'(cnt3), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hs_fifo.md
HS_FIFO -- requirements
Module: hs_fifo

Interface
REQ-001 Parameter WIDTH, default 1, data word width in bits; legal range is 1 or more.
REQ-002 Parameter DEPTH, default 4, storage entries; legal range is 2 or more, and need not be a power of two.
REQ-003 Parameter AFULL_LEVEL, default DEPTH-1, occupancy at or above which almost_full asserts; legal range is 1..DEPTH.
REQ-004 Port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit; reset is synchronous and active-high.
REQ-006 Port flush, input, 1 bit, synchronous clear of contents; lower priority than rst.
REQ-007 Port in_valid, input, 1 bit, producer offers in_data this cycle.
REQ-008 Port in_ready, output, 1 bit, FIFO accepts a word this cycle.
REQ-009 Port in_data, input, WIDTH bits, write data.
REQ-010 Port out_valid, output, 1 bit, out_data holds the oldest stored word.
REQ-011 Port out_ready, input, 1 bit, consumer takes out_data this cycle.
REQ-012 Port out_data, output, WIDTH bits, head-of-queue data (show-ahead).
REQ-013 Port count, output, $clog2(DEPTH+1) bits, current occupancy 0..DEPTH.
REQ-014 Port almost_full, output, 1 bit, asserted when count >= AFULL_LEVEL.

Function
REQ-015 push = in_valid & in_ready; pop = out_valid & out_ready; transfers occur only on these qualified events.
REQ-016 in_ready shall equal (count != DEPTH), a registered-state function only, with no combinational path from out_ready.
REQ-017 out_valid shall equal (count != 0), with no combinational path from in_valid.
REQ-018 Storage is DEPTH flip-flop entries addressed by write and read pointers that wrap from DEPTH-1 to 0, including for non-power-of-two DEPTH.
REQ-019 Push alone: write in_data at the write pointer, advance the write pointer, count+1.
REQ-020 Pop alone: advance the read pointer, count-1.
REQ-021 Push and pop in the same cycle (0 < count < DEPTH): both pointers advance and count is unchanged.
REQ-022 When empty, pop cannot occur; a push makes the word visible on out_data with out_valid=1 the next cycle (latency 1).
REQ-023 When full, in_ready=0, so the push is refused even if a pop occurs the same cycle; in_ready returns to 1 the cycle after the pop.
REQ-024 out_data shall be the entry at the read pointer; its value is don't-care while out_valid=0.
REQ-025 Ordering is strict FIFO; no word is dropped, duplicated or reordered.
REQ-026 almost_full is registered-state derived; it updates in the same cycle count changes.
REQ-027 flush=1 sets count and both pointers to 0, discards any push or pop in that cycle, and leaves storage contents unchanged.
REQ-028 Parameter legality (DEPTH<2, AFULL_LEVEL outside 1..DEPTH) shall be checked at elaboration; elaboration fails on violation.

Reset
REQ-029 rst=1 at a clock edge sets count=0, pointers=0, all storage entries=0, so in_ready=1, out_valid=0, almost_full=0 and out_data=0 from the next cycle.
REQ-030 rst has priority over flush, push and pop in the same cycle.
REQ-031 A reset mid-operation (FIFO partly full, transfers in flight) discards all contents; no pre-reset word appears on out_data after reset.

Verification
REQ-032 WIDTH=8, DEPTH=4: push 0x11,0x22,0x33,0x44 with out_ready=0 -> count 1,2,3,4; in_ready=0 after the 4th push; almost_full=1 from count=3.
REQ-033 Full FIFO, in_valid=1 and out_ready=1 for one cycle -> 0x11 popped, nothing written, count=3; next cycle in_ready=1.
REQ-034 count=2, push and pop every cycle for 10 cycles with incrementing data -> count stays 2, output sequence is in order, pointers wrap without loss.
REQ-035 Empty, push 0xA5 at cycle N -> out_valid=1 and out_data=0xA5 at cycle N+1; out_valid=0 before that.
REQ-036 count=3, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1; the flushed-cycle word is not stored.
REQ-037 DEPTH=3 (non-power-of-two), stream 20 random words under random valid/ready -> scoreboard matches exactly; rst asserted mid-stream -> count=0, out_valid=0 the next cycle.
